// File: rtl/gray_conv_pkg.sv
// rtl/gray_conv_pkg.sv - shared FSM state type and default sizes for gray_conv_sched
package gray_conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/gray_conv_sched_rr_arbiter.sv
// rtl/gray_conv_sched_rr_arbiter.sv - round-robin grant: first active request at or after ptr
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   int cand;

   // scan requesters starting at ptr, wrapping, and pick the first one asserting req
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/gray_conv_sched.sv
// rtl/gray_conv_sched.sv - shared gray-to-binary converter with round-robin requesters; GRAY_CONV_SCHED_FAST_EN selects single-cycle conversion
module gray_conv_sched
   import gray_conv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_gray,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_binary,
   output logic [$clog2(NREQ)-1:0] out_id
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    gidx;
   logic             any;
   logic             take;
   logic [IW-1:0]    rr_ptr;
   logic [CW-1:0]    bitcnt;
   logic [WIDTH-1:0] gray_q;
   logic             acc;
   logic [WIDTH-1:0] sel_gray;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   assign sel_gray  = req_gray[gidx*WIDTH +: WIDTH];
   assign out_valid = (state == DONE);

`ifdef GRAY_CONV_SCHED_FAST_EN
   logic [WIDTH-1:0] fast_bin;

   // binary bit k is the parity of all gray bits at k and above
   always_comb begin
      fast_bin = '0;
      for (int k = 0; k < WIDTH; k++) begin
         fast_bin[k] = ^(sel_gray >> k);
      end
   end
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and the one-cycle accept strobe; reset masks the strobe since IDLE is the reset state
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (any && !rst) begin
               req_ready = grant;
               take      = 1'b1;
`ifdef GRAY_CONV_SCHED_FAST_EN
               state_nxt = DONE;
`else
               state_nxt = CONV;
`endif
            end
         end
         CONV: begin
            if (bitcnt == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // capture on grant, then (serial build) resolve one binary bit per cycle MSB-first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         bitcnt     <= '0;
         gray_q     <= '0;
         acc        <= 1'b0;
         out_binary <= '0;
         out_id     <= '0;
      end else if (take) begin
         rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
         out_id <= gidx;
         gray_q <= sel_gray;
         bitcnt <= CW'(WIDTH - 1);
         acc    <= 1'b0;
`ifdef GRAY_CONV_SCHED_FAST_EN
         out_binary <= fast_bin;
`endif
      end
`ifndef GRAY_CONV_SCHED_FAST_EN
      else if (state == CONV) begin
         out_binary[bitcnt] <= acc ^ gray_q[bitcnt];
         acc                <= acc ^ gray_q[bitcnt];
         if (bitcnt != '0) begin
            bitcnt <= bitcnt - 1'b1;
         end
      end
`endif
   end

endmodule

// File: doc/gray_conv_sched.md
GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning gray/binary word width in bits (>=2).
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters sharing the converter (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester conversion request.
REQ-006 SHALL have port req_gray  input  NREQ*WIDTH  gray words, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_ready  output  NREQ  one-hot accept strobe to the granted requester.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_binary  output  WIDTH  converted binary word.
REQ-011 SHALL have port out_id  output  $clog2(NREQ)  index of the requester that owns out_binary.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with any req_valid high, grant round-robin starting at pointer rr_ptr: req_ready[g]=1 combinationally for that cycle only, capture req_gray[g] and g, and go to CONV.
REQ-014 SHALL keep req_ready all-zero in CONV and DONE, and in IDLE when no req_valid is high.
REQ-015 SHALL set rr_ptr to (g+1) mod NREQ on each grant; a requester dropping req_valid before a grant is simply skipped.
REQ-016 SHALL convert serially MSB-first in CONV: bit counter from WIDTH-1 down to 0, one bit per cycle, bin[WIDTH-1]=gray[WIDTH-1], bin[k]=bin[k+1]^gray[k]; after bit 0 go to DONE.
REQ-017 SHALL take exactly WIDTH cycles in CONV, so out_valid rises WIDTH+1 cycles after the grant edge.
REQ-018 SHALL hold out_valid=1 with stable out_binary and out_id in DONE until out_valid&&out_ready, then return to IDLE on that edge.
REQ-019 SHALL not accept a new request in the cycle the result is consumed; the next grant is at earliest one cycle later in IDLE (no overlap).
REQ-020 SHALL drive out_binary and out_id from registers; their values are don't-care when out_valid=0 but never X after reset.

Reset
REQ-021 SHALL on rst=1, immediately and regardless of clk: state=IDLE, rr_ptr=0, bit counter=0, captured word=0, out_valid=0, out_binary=0, out_id=0, req_ready=0.
REQ-022 SHALL abandon any conversion in progress or pending result on reset mid-operation with no output; the requester re-requests.

Configuration
REQ-023 SHALL support macro GRAY_CONV_SCHED_FAST_EN: when defined, conversion is a single-cycle combinational XOR prefix performed at grant and the FSM goes IDLE -> DONE directly (out_valid one cycle after grant); when undefined, the serial CONV path of REQ-016/017 applies.
REQ-024 SHALL present identical ports, handshake rules and results with and without the macro; only latency differs.

Structure
REQ-025 SHALL place the state enum (IDLE, CONV, DONE) and default WIDTH/NREQ constants in shared package gray_conv_pkg.
REQ-026 SHALL isolate the round-robin grant logic in sub-module rr_arbiter (inputs req, ptr; output one-hot grant and encoded index).

Verification (WIDTH=4, NREQ=4, serial build unless stated)
REQ-027 SHALL check: req 0 only, gray 0110 -> req_ready[0] one cycle, out_valid 5 cycles later, out_binary 0100, out_id 0.
REQ-028 SHALL check: all four valid with gray 1000/1111/0001/0011, out_ready=1 -> results in order id 0,1,2,3 = 1111, 1010, 0001, 0010.
REQ-029 SHALL check: out_ready held 0 for 10 cycles in DONE -> out_valid, out_binary and out_id stable, req_ready all 0.
REQ-030 SHALL check: rst pulsed during CONV cycle 2 -> out_valid=0 and state IDLE immediately; a subsequent gray 1111 yields 1010.
REQ-031 SHALL check: GRAY_CONV_SCHED_FAST_EN defined, gray 0110 -> out_valid one cycle after grant with 0100.
REQ-032 SHALL check: exhaustive 0000..1111 on requester 2 in both builds -> out_binary equals reference prefix-XOR for all 16 values.
